// File: rtl/lighthouse_pulse_decoder.sv
// rtl/lighthouse_pulse_decoder.sv - classifies sensor pulses as sync/sweep/glitch and reports
// sweep timing relative to the arming sync pulse.
module lighthouse_pulse_decoder #(
  parameter int WIDTH           = 32,
  parameter int SYNC_MIN_TICKS  = 2000,
  parameter int SYNC_BASE_TICKS = 3000,
  parameter int SYNC_STEP_TICKS = 500,
  parameter int MIN_PULSE_TICKS = 24,
  parameter int MAX_SWEEP_TICKS = 400000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] center_in,
  input  logic             center_ready,
  output logic             sync_valid,
  output logic [2:0]       sync_code,
  output logic             sweep_valid,
  output logic [WIDTH-1:0] sweep_ticks,
  output logic             sweep_axis,
  output logic             drop,
  output logic             armed
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] SYNC_MIN  = WIDTH'(SYNC_MIN_TICKS);
  localparam logic [WIDTH-1:0] MIN_PULSE = WIDTH'(MIN_PULSE_TICKS);
  localparam logic [WIDTH-1:0] MAX_SWEEP = WIDTH'(MAX_SWEEP_TICKS);

  // Lower bound of sync code k: midpoint between nominal widths of codes k-1 and k.
  function automatic logic [WIDTH-1:0] sync_thr(input int k);
    return WIDTH'(SYNC_BASE_TICKS + k * SYNC_STEP_TICKS - SYNC_STEP_TICKS / 2);
  endfunction

  state_t           state_q;
  logic             signal_q;
  logic             ready_q;
  logic             pulse_seen_q;
  logic [WIDTH-1:0] rise_time_q;
  logic [WIDTH-1:0] last_rise_q;
  logic [WIDTH-1:0] last_width_q;
  logic [WIDTH-1:0] ref_time_q;
  logic             ref_axis_q;
  logic             sync_valid_q;
  logic [2:0]       sync_code_q;
  logic             sweep_valid_q;
  logic [WIDTH-1:0] sweep_ticks_q;
  logic             sweep_axis_q;
  logic             drop_q;

  logic             rise_edge;
  logic             fall_edge;
  logic             event_fire;
  logic [2:0]       code_d;
  logic             is_sync;
  logic             is_glitch;
  logic [WIDTH-1:0] sweep_d;
  logic             sweep_in_range;
  logic [WIDTH-1:0] elapsed;
  logic             timed_out;

  assign rise_edge      = signal & ~signal_q;
  assign fall_edge      = ~signal & signal_q;
  assign event_fire     = center_ready & ~ready_q & pulse_seen_q;
  assign is_sync        = (last_width_q >= SYNC_MIN);
  assign is_glitch      = (last_width_q < MIN_PULSE);
  assign sweep_d        = center_in - ref_time_q;
  assign sweep_in_range = (sweep_d <= MAX_SWEEP);
  assign elapsed        = counter - ref_time_q;
  assign timed_out      = (elapsed > MAX_SWEEP);

  // Thresholds rise monotonically, so the last one passed is the saturated code.
  always_comb begin
    code_d = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (last_width_q >= sync_thr(k)) begin
        code_d = 3'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      signal_q      <= 1'b0;
      ready_q       <= 1'b0;
      pulse_seen_q  <= 1'b0;
      rise_time_q   <= '0;
      last_rise_q   <= '0;
      last_width_q  <= '0;
      ref_time_q    <= '0;
      ref_axis_q    <= 1'b0;
      sync_valid_q  <= 1'b0;
      sync_code_q   <= 3'd0;
      sweep_valid_q <= 1'b0;
      sweep_ticks_q <= '0;
      sweep_axis_q  <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      signal_q      <= signal;
      ready_q       <= center_ready;
      sync_valid_q  <= 1'b0;
      sweep_valid_q <= 1'b0;
      drop_q        <= 1'b0;

      if (rise_edge) begin
        rise_time_q <= counter;
      end
      if (fall_edge) begin
        last_rise_q  <= rise_time_q;
        last_width_q <= counter - rise_time_q;
        pulse_seen_q <= 1'b1;
      end

      // Event uses only the latched pulse, so a new rise this cycle cannot disturb it.
      if (event_fire) begin
        if (is_sync) begin
          sync_valid_q <= 1'b1;
          sync_code_q  <= code_d;
          if (!code_d[2]) begin
            ref_time_q <= last_rise_q;
            ref_axis_q <= code_d[0];
            state_q    <= ARMED;
          end
        end else if (!is_glitch) begin
          if (state_q == ARMED && sweep_in_range) begin
            sweep_valid_q <= 1'b1;
            sweep_ticks_q <= sweep_d;
            sweep_axis_q  <= ref_axis_q;
          end else begin
            drop_q <= 1'b1;
          end
          state_q <= IDLE;
        end
      end else if (state_q == ARMED && timed_out) begin
        state_q <= IDLE;
      end
    end
  end

  assign sync_valid  = sync_valid_q;
  assign sync_code   = sync_code_q;
  assign sweep_valid = sweep_valid_q;
  assign sweep_ticks = sweep_ticks_q;
  assign sweep_axis  = sweep_axis_q;
  assign drop        = drop_q;
  assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// tb/tb_lighthouse_pulse_decoder.sv - pulse-level reference model with per-cycle output checks.
module tb_lighthouse_pulse_decoder;

  localparam int SYNC_MIN  = 2000;
  localparam int SYNC_BASE = 3000;
  localparam int SYNC_STEP = 500;
  localparam int MIN_PULSE = 24;
  localparam int MAX_SWEEP = 400000;

  logic        clk = 1'b0;
  logic        rst;
  logic        signal;
  logic [31:0] counter;
  logic [31:0] center_in;
  logic        center_ready;
  logic        sync_valid;
  logic [2:0]  sync_code;
  logic        sweep_valid;
  logic [31:0] sweep_ticks;
  logic        sweep_axis;
  logic        drop;
  logic        armed;

  lighthouse_pulse_decoder #(
    .WIDTH(32), .SYNC_MIN_TICKS(SYNC_MIN), .SYNC_BASE_TICKS(SYNC_BASE),
    .SYNC_STEP_TICKS(SYNC_STEP), .MIN_PULSE_TICKS(MIN_PULSE), .MAX_SWEEP_TICKS(MAX_SWEEP)
  ) dut (
    .clk(clk), .rst(rst), .signal(signal), .counter(counter), .center_in(center_in),
    .center_ready(center_ready), .sync_valid(sync_valid), .sync_code(sync_code),
    .sweep_valid(sweep_valid), .sweep_ticks(sweep_ticks), .sweep_axis(sweep_axis),
    .drop(drop), .armed(armed)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state, at the level of whole pulses.
  bit          m_armed, m_seen, m_ref_axis, m_axis;
  logic [31:0] m_ref, m_ticks;
  logic [2:0]  m_code;
  bit          e_sv, e_wv, e_drop;
  bit          ev_now, ev_fall;
  logic [31:0] ev_rise, ev_w, ev_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sync_valid", sync_valid, e_sv);
      chk("sweep_valid", sweep_valid, e_wv);
      chk("drop", drop, e_drop);
      chk("armed", armed, m_armed);
      chk("sync_code", sync_code, m_code);
      chk("sweep_ticks", sweep_ticks, m_ticks);
      chk("sweep_axis", sweep_axis, m_axis);
    end
  end

  function automatic int code_of(input int w);
    int c;
    c = (w - (SYNC_BASE - SYNC_STEP / 2)) / SYNC_STEP;
    if (c < 0) c = 0;
    if (c > 7) c = 7;
    return c;
  endfunction

  task automatic reset_model();
    m_armed = 0; m_seen = 0; m_ref = 0; m_ref_axis = 0;
    m_code = 0; m_ticks = 0; m_axis = 0;
  endtask

  task automatic tick();
    bit          to;
    bit          fire;
    int          c;
    logic [31:0] d;
    fire = ev_now && m_seen;
    to = m_armed && !fire && ((counter - m_ref) > 32'(MAX_SWEEP));
    @(posedge clk);
    #1;
    e_sv = 0; e_wv = 0; e_drop = 0;
    if (rst) begin
      reset_model();
    end else begin
      if (fire) begin
        if (ev_w >= 32'(SYNC_MIN)) begin
          c = code_of(int'(ev_w));
          e_sv = 1;
          m_code = 3'(c);
          if (c < 4) begin
            m_armed = 1; m_ref = ev_rise; m_ref_axis = c[0];
          end
        end else if (ev_w >= 32'(MIN_PULSE)) begin
          d = ev_c - m_ref;
          if (m_armed && d <= 32'(MAX_SWEEP)) begin
            e_wv = 1; m_ticks = d; m_axis = m_ref_axis;
          end else begin
            e_drop = 1;
          end
          m_armed = 0;
        end
      end else if (to) begin
        m_armed = 0;
      end
      if (ev_fall) m_seen = 1;
    end
    ev_now = 0;
    ev_fall = 0;
  endtask

  // Leaves outputs of the decode visible on return.
  task automatic pulse(input logic [31:0] rise, input logic [31:0] fall, input logic [31:0] centre);
    signal = 1; counter = rise; tick();
    signal = 0; counter = fall; ev_fall = 1; tick();
    counter = fall + 1; center_ready = 1; center_in = centre;
    ev_now = 1; ev_rise = rise; ev_w = fall - rise; ev_c = centre;
    tick();
  endtask

  task automatic settle();
    center_ready = 0; counter = counter + 1; tick();
    counter = counter + 1; tick();
  endtask

  initial begin
    rst = 1; signal = 0; counter = 0; center_in = 0; center_ready = 0;
    ev_now = 0; ev_fall = 0; e_sv = 0; e_wv = 0; e_drop = 0;
    reset_model();
    tick(); tick();
    rst = 0;
    chk_en = 1;
    chk("reset_armed", armed, 0);
    chk("reset_ticks", sweep_ticks, 0);

    // Code-0 sync then sweep
    pulse(1000, 4000, 2500);
    chk("t1_sync_valid", sync_valid, 1);
    chk("t1_sync_code", sync_code, 0);
    settle();
    chk("t1_armed", armed, 1);
    pulse(100000, 100200, 100100);
    chk("t1_sweep_valid", sweep_valid, 1);
    chk("t1_ticks", sweep_ticks, 99100);
    chk("t1_armed_after", armed, 0);
    settle();

    // Skip sync (code 5) does not arm; sweep dropped
    pulse(200000, 205500, 202750);
    chk("t2_code", sync_code, 5);
    chk("t2_armed", armed, 0);
    settle();
    pulse(210000, 210200, 210100);
    chk("t2_drop", drop, 1);
    chk("t2_sweep_valid", sweep_valid, 0);
    settle();

    // Counter wrap with code-1 sync
    pulse(32'hFFFFF000, 32'hFFFFF000 + 3500, 32'hFFFFF6D6);
    chk("t3_code", sync_code, 1);
    settle();
    pulse(32'h00001F9C, 32'h00002064, 32'h00002000);
    chk("t3_ticks", sweep_ticks, 32'h3000);
    chk("t3_axis", sweep_axis, 1);
    settle();

    // Timeout boundary
    pulse(0, 3000, 1500);
    settle();
    counter = 400000; tick();
    chk("t4_armed_at_max", armed, 1);
    counter = 400001; tick();
    chk("t4_armed_timeout", armed, 0);
    pulse(410000, 410200, 410100);
    chk("t4_drop", drop, 1);
    settle();

    // Glitch ignored while armed
    pulse(500000, 503000, 501500);
    settle();
    pulse(520000, 520010, 520005);
    chk("t5_glitch_armed", armed, 1);
    settle();
    pulse(540000, 540200, 550000);
    chk("t5_ticks", sweep_ticks, 50000);
    settle();

    // Reset while armed; stray ready ignored; next sweep dropped
    pulse(600000, 603000, 601500);
    settle();
    rst = 1; tick(); tick();
    rst = 0;
    chk("t6_armed", armed, 0);
    chk("t6_code", sync_code, 0);
    center_ready = 1; center_in = 32'd650000; ev_now = 1; ev_rise = 0; ev_w = 200; ev_c = 650000;
    tick();
    settle();
    pulse(700000, 700200, 700100);
    chk("t6_drop", drop, 1);
    settle();

    // One-cycle-low gap: second pulse rises in the first pulse's event cycle
    signal = 1; counter = 800000; tick();
    signal = 0; counter = 803000; ev_fall = 1; tick();
    signal = 1; counter = 803001; center_ready = 1; center_in = 801500;
    ev_now = 1; ev_rise = 800000; ev_w = 3000; ev_c = 801500; tick();
    chk("t7_sync", sync_valid, 1);
    center_ready = 0; counter = 803002; tick();
    signal = 0; counter = 803201; ev_fall = 1; tick();
    counter = 803202; center_ready = 1; center_in = 803101;
    ev_now = 1; ev_rise = 803001; ev_w = 200; ev_c = 803101; tick();
    chk("t7_sweep", sweep_valid, 1);
    chk("t7_ticks", sweep_ticks, 3101);
    settle();

    // Width boundaries, checked by the model each cycle
    begin
      int widths[8] = '{1999, 2000, 3249, 3250, 4500, 9000, 23, 24};
      for (int i = 0; i < 8; i++) begin
        logic [31:0] r;
        r = 32'(900000 + i * 20000);
        pulse(r, r + 32'(widths[i]), r + 32'(widths[i] / 2));
        settle();
      end
    end
    chk("t8_code_sat", sync_code, 7);

    chk_en = 0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
